// File: rtl/seven_seg_scan.sv
// seven_seg_scan: N-digit multiplexed seven-segment driver with PWM brightness, dead-time blank
// and per-slot input latching. Defining SEVEN_SEG_BLINK_EN adds blink_mask and a blink counter.
module seven_seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int CLK_DIV     = 100000,
    parameter int BRIGHT_W    = 4
`ifdef SEVEN_SEG_BLINK_EN
    ,
    parameter int BLINK_SLOTS = 256
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7*NUM_DIGITS-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [BRIGHT_W-1:0]     brightness,
`ifdef SEVEN_SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [6:0]              cathode,
    output logic                    scan_tick
);
    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int PROD_W = CNT_W + BRIGHT_W + 1;
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] I_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      p_q, p_d;
    logic [IDX_W-1:0]      i_q, i_d;
    logic [6:0]            pat_q, pat_d;
    logic                  en_q, en_d;
    logic [BRIGHT_W-1:0]   bright_q, bright_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            cathode_q, cathode_d;
    logic                  tick_q, tick_d;

    logic                  wrap;
    logic [6:0]            sel_pat;
    logic                  sel_en;
    logic [PROD_W-1:0]     prod;
    logic [PROD_W-1:0]     on_cycles;
    logic                  blink_dark;
    logic                  lit;

`ifdef SEVEN_SEG_BLINK_EN
    localparam int BLK_N = BLINK_SLOTS * NUM_DIGITS;
    localparam int BLK_W = $clog2(BLK_N);
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             bmask_q, bmask_d;
    logic             sel_bmask;
`endif

    // Slot input mux: pick the pattern and enable of the digit currently being scanned.
    always_comb begin
        sel_pat = 7'h7F;
        sel_en  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (i_q == IDX_W'(k)) begin
                sel_pat = seg_in[7*k +: 7];
                sel_en  = digit_en[k];
            end
        end
    end

    always_comb begin
        wrap     = (p_q == P_LAST);
        p_d      = wrap ? '0 : p_q + 1'b1;
        i_d      = i_q;
        if (wrap) begin
            i_d = (i_q == I_LAST) ? '0 : i_q + 1'b1;
        end
        tick_d   = wrap;
        pat_d    = pat_q;
        en_d     = en_q;
        bright_d = bright_q;
        if (p_q == '0) begin
            pat_d    = sel_pat;
            en_d     = sel_en;
            bright_d = brightness;
        end
    end

`ifdef SEVEN_SEG_BLINK_EN
    always_comb begin
        sel_bmask = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (i_q == IDX_W'(k)) begin
                sel_bmask = blink_mask[k];
            end
        end
        bmask_d = (p_q == '0) ? sel_bmask : bmask_q;
        blk_d   = blk_q;
        if (tick_q) begin
            blk_d = (blk_q == BLK_W'(BLK_N - 1)) ? '0 : blk_q + 1'b1;
        end
        blink_dark = blk_q[BLK_W-1] && bmask_q;
    end
`else
    always_comb begin
        blink_dark = 1'b0;
    end
`endif

    // p == 0 is the dead-time cycle; the product is wide enough to never overflow.
    always_comb begin
        prod      = (PROD_W'(bright_q) + PROD_W'(1)) * PROD_W'(CLK_DIV - 1);
        on_cycles = prod >> BRIGHT_W;
        lit       = en_q && !blink_dark && (p_q != '0) && (PROD_W'(p_q) <= on_cycles);
        an_d      = lit ? ~(NUM_DIGITS'(1) << i_q) : '1;
        cathode_d = lit ? pat_q : 7'h7F;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q       <= '0;
            i_q       <= '0;
            pat_q     <= 7'h7F;
            en_q      <= 1'b0;
            bright_q  <= '0;
            an_q      <= '1;
            cathode_q <= 7'h7F;
            tick_q    <= 1'b0;
        end else begin
            p_q       <= p_d;
            i_q       <= i_d;
            pat_q     <= pat_d;
            en_q      <= en_d;
            bright_q  <= bright_d;
            an_q      <= an_d;
            cathode_q <= cathode_d;
            tick_q    <= tick_d;
        end
    end

`ifdef SEVEN_SEG_BLINK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_q   <= '0;
            bmask_q <= 1'b0;
        end else begin
            blk_q   <= blk_d;
            bmask_q <= bmask_d;
        end
    end
`endif

    assign AN        = an_q;
    assign cathode   = cathode_q;
    assign scan_tick = tick_q;

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Parametrised N-digit multiplexed seven-segment driver. Successor to the fixed 4-digit scanner.
- Takes one raw active-low cathode pattern per digit, time-multiplexes the patterns onto a shared cathode bus and drives active-low anodes.
- Adds a per-digit enable mask, PWM brightness control, an inter-digit dead-time blank and glitch-free latching of the patterns.
- Sits between the timer/BCD-to-segment logic and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; legal range 2..8.
- CLK_DIV, 100000: clk cycles per digit slot; minimum 4.
- BRIGHT_W, 4: width of the brightness input.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- seg_in  in  7*NUM_DIGITS  raw active-low cathode patterns. Digit k occupies bits [7k+6:7k]. Digit 0 is the rightmost digit and drives AN[0].
- digit_en  in  NUM_DIGITS  1 = digit k is displayed; 0 = digit k stays dark for its whole slot.
- brightness  in  BRIGHT_W  on-time duty within each slot; all-ones = maximum brightness.
- AN  out  NUM_DIGITS  active-low anodes; at most one bit is low in any cycle.
- cathode  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- scan_tick  out  1  one-cycle pulse when the digit index advances.

Behaviour:
- Reset (synchronous, active-high) sets:
  - AN = all ones, cathode = 7'b1111111, scan_tick = 0.
  - Prescaler p = 0, digit index i = 0, latched pattern = 7'b1111111.
- Reset takes effect on the first rising edge with reset = 1 and holds every value while reset stays high. A reset in the middle of a slot aborts that slot immediately.
- Prescaler:
  - p counts 0..CLK_DIV-1, then wraps to 0.
  - On the wrap, i advances as i = (i == NUM_DIGITS-1) ? 0 : i+1.
  - scan_tick is registered and is high for exactly the one cycle after the wrap edge. Its period is CLK_DIV cycles.
- Latching: at p == 0, the module captures seg_in[7i+6:7i], digit_en[i] and brightness for the current slot. Changes on these inputs mid-slot have no effect until the next slot.
- On-time: on_cycles = ((latched_brightness + 1) * (CLK_DIV - 1)) >> BRIGHT_W, using integer arithmetic at full width with no overflow.
- Light condition: the digit lights when latched_en == 1 and 1 <= p <= on_cycles.
  - p == 0 is always blank (dead-time, anti-ghosting).
  - Maximum brightness therefore lights p = 1..CLK_DIV-1.
  - brightness = 0 gives on_cycles = (CLK_DIV-1) >> BRIGHT_W; if that is 0, the digit is dark.
- Outputs (registered, one-cycle latency from p/i state):
  - When lit: AN = ~(1 << i) and cathode = latched pattern.
  - Otherwise: AN = all ones and cathode = 7'b1111111.
- The cathode never changes while an anode is low. Pattern changes happen only at p == 0, when everything is blank.
- If every digit_en bit is 0, the display is fully dark but scanning and scan_tick continue.

Optional Feature:
- Macro: SEVEN_SEG_BLINK_EN.
- When defined:
  - Adds input blink_mask [NUM_DIGITS-1:0] and parameter BLINK_SLOTS (default 256).
  - A blink counter advances on each scan_tick and wraps after BLINK_SLOTS * NUM_DIGITS ticks.
  - While the counter MSB is 1, any digit whose latched blink_mask bit is 1 is forced dark.
  - The blink counter clears on reset.
  - The blink_mask bit is latched at p == 0 together with the other slot inputs.
- When undefined: no blink_mask port and no blink counter; behaviour is exactly as described above.

Test Plan:
- Bench settings for all scenarios: NUM_DIGITS=4, CLK_DIV=16, BRIGHT_W=4.
- Reset/idle: assert reset for 2 cycles, then release with brightness=4'hF, digit_en=4'hF, seg_in={7'h19,7'h30,7'h24,7'h79}.
  - During reset: AN=4'b1111, cathode=7'h7F, scan_tick=0.
  - After release: AN=4'b1110 with cathode=7'h79 lit for 15 cycles, then AN=4'b1101 with cathode=7'h24, and so on in order 0,1,2,3,0.
- Dead time: across every slot boundary, exactly one cycle with AN=4'b1111 and cathode=7'h7F. A bench checker flags any cycle with more than one AN bit low.
- Brightness: brightness=4'h7 gives on_cycles=(8*15)>>4=7, so each digit is lit 7 of 16 cycles. brightness=4'h0 gives on_cycles=0, so the display stays dark while scan_tick still pulses every 16 cycles.
- Enable mask and latching: with digit_en=4'b0101, digits 1 and 3 are never lit. Changing seg_in for digit 0 mid-slot must not alter cathode until digit 0's next slot.
- Reset mid-slot: assert reset at p=5 of digit 2. On the next edge AN=4'b1111, and after release scanning restarts at digit 0 from p=0.
- Blink (SEVEN_SEG_BLINK_EN, BLINK_SLOTS=2): blink_mask=4'b0001 makes digit 0 dark for 4 consecutive scan_ticks out of every 8, while digits 1-3 are unaffected.
